paddle_controller: RTL and testbench

- Per-frame motion sequencer for the two game paddles.
- On each rising edge of the VGA frame clock it samples the keyboard keycodes and steps each paddle's vertical position in turn, with speed ramping and clamping at the screen bounds.
- It publishes registered positions and half-height to the paddle ellipse detectors (X, Y, size inputs) and pulses a done flag for downstream collision logic.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/paddle_controller_if.sv | 25 ++
 rtl/paddle_step.sv | 63 ++++++
 rtl/paddle_controller.sv | 153 +++++++++++++++
 tb/tb_paddle_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the paddle motion sequencer.
package pong_pkg;

    typedef enum logic [2:0] {IDLE, SAMPLE, MOVE0, MOVE1, DONE} paddle_state_t;

    typedef logic signed [1:0] dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int POS_W   = 10;
    localparam int SPEED_W = 4;
    localparam int CAND_W  = 12;

    // Holding both keys cancels out, the same as holding neither.
    function automatic dir_t key_dir(input logic up, input logic dn);
        if (up && !dn)
            return -2'sd1;
        else if (dn && !up)
            return 2'sd1;
        else
            return 2'sd0;
    endfunction

endpackage

// File: rtl/paddle_controller_if.sv
// Keyboard/frame inputs and paddle-detector outputs of the paddle controller.
interface paddle_controller_if;

    logic       frame_clk;
    logic       hold;
    logic [7:0] keycode0;
    logic [7:0] keycode1;
    logic [9:0] Paddle0X;
    logic [9:0] Paddle0Y;
    logic [9:0] Paddle1X;
    logic [9:0] Paddle1Y;
    logic [9:0] paddle_size;
    logic       update_done;

    modport master (
        output frame_clk, hold, keycode0, keycode1,
        input  Paddle0X, Paddle0Y, Paddle1X, Paddle1Y, paddle_size, update_done
    );

    modport slave (
        input  frame_clk, hold, keycode0, keycode1,
        output Paddle0X, Paddle0Y, Paddle1X, Paddle1Y, paddle_size, update_done
    );

endinterface

// File: rtl/paddle_step.sv
// One frame of paddle motion: direction from keys, speed ramp, move and clamp.
module paddle_step
    import pong_pkg::*;
#(
    parameter int PADDLE_HALF = 24,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int MAX_SPEED   = 6
) (
    input  logic [POS_W-1:0]   y,
    input  logic [SPEED_W-1:0] speed,
    input  dir_t               prev_dir,
    input  logic               up,
    input  logic               dn,
    output logic [POS_W-1:0]   next_y,
    output logic [SPEED_W-1:0] next_speed,
    output dir_t               next_dir
);

    localparam logic signed [CAND_W-1:0] LO = CAND_W'(Y_MIN + PADDLE_HALF);
    localparam logic signed [CAND_W-1:0] HI = CAND_W'(Y_MAX - PADDLE_HALF);
    localparam logic [SPEED_W-1:0]       SPEED_CAP = SPEED_W'(MAX_SPEED);

    dir_t                      dir;
    logic [SPEED_W-1:0]        spd;
    logic signed [CAND_W-1:0]  y_ext;
    logic signed [CAND_W-1:0]  mag;
    logic signed [CAND_W-1:0]  cand;

    always_comb begin
        dir = key_dir(up, dn);

        if (dir == 2'sd0)
            spd = '0;
        else if (dir == prev_dir)
            spd = (speed >= SPEED_CAP) ? SPEED_CAP : speed + SPEED_W'(1);
        else
            spd = SPEED_W'(1);

        y_ext = signed'({{(CAND_W-POS_W){1'b0}}, y});
        mag   = signed'({{(CAND_W-SPEED_W){1'b0}}, spd});

        if (dir == -2'sd1)
            cand = y_ext - mag;
        else if (dir == 2'sd1)
            cand = y_ext + mag;
        else
            cand = y_ext;

        next_dir   = dir;
        next_speed = spd;
        next_y     = cand[POS_W-1:0];
        // Hitting a wall kills the momentum so the next press starts slow.
        if (cand < LO) begin
            next_y     = LO[POS_W-1:0];
            next_speed = '0;
        end else if (cand > HI) begin
            next_y     = HI[POS_W-1:0];
            next_speed = '0;
        end
    end

endmodule

// File: rtl/paddle_controller.sv
// Per-frame paddle sequencer: samples keys on each frame edge, then steps paddle 0 and paddle 1.
module paddle_controller
    import pong_pkg::*;
#(
    parameter int         PADDLE_HALF = 24,
    parameter int         Y_MIN       = 0,
    parameter int         Y_MAX       = 479,
    parameter int         Y_INIT      = 240,
    parameter int         P0_X        = 40,
    parameter int         P1_X        = 600,
    parameter int         MAX_SPEED   = 6,
    parameter logic [7:0] KEY_UP0     = 8'h1A,
    parameter logic [7:0] KEY_DN0     = 8'h16,
    parameter logic [7:0] KEY_UP1     = 8'h52,
    parameter logic [7:0] KEY_DN1     = 8'h51
) (
    input logic                Clk,
    input logic                Reset,
    paddle_controller_if.slave bus
);

    paddle_state_t state, next_state;

    logic sync_1, sync_2, frame_prev, frame_rise;
    logic load_snap, load0, load1, done;

    logic up0_snap, dn0_snap, up1_snap, dn1_snap;
    logic up0_key, dn0_key, up1_key, dn1_key;

    logic [POS_W-1:0]   y0, y1, step_y, next_y;
    logic [SPEED_W-1:0] spd0, spd1, step_spd, next_spd;
    dir_t               pdir0, pdir1, step_pdir, next_dir;
    logic               sel1, step_up, step_dn;

    // frame_clk comes from the VGA domain; two flops plus a history flop for the edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            frame_prev <= 1'b0;
        end else begin
            sync_1     <= bus.frame_clk;
            sync_2     <= sync_1;
            frame_prev <= sync_2;
        end
    end

    assign frame_rise = sync_2 & ~frame_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_snap  = 1'b0;
        load0      = 1'b0;
        load1      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE:    if (frame_rise && !bus.hold) next_state = SAMPLE;
            SAMPLE: begin
                load_snap  = 1'b1;
                next_state = MOVE0;
            end
            MOVE0: begin
                load0      = 1'b1;
                next_state = MOVE1;
            end
            MOVE1: begin
                load1      = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign up0_key = (bus.keycode0 == KEY_UP0) | (bus.keycode1 == KEY_UP0);
    assign dn0_key = (bus.keycode0 == KEY_DN0) | (bus.keycode1 == KEY_DN0);
    assign up1_key = (bus.keycode0 == KEY_UP1) | (bus.keycode1 == KEY_UP1);
    assign dn1_key = (bus.keycode0 == KEY_DN1) | (bus.keycode1 == KEY_DN1);

    // A single stepper serves both paddles; MOVE1 switches it to paddle 1.
    assign sel1      = (state == MOVE1);
    assign step_y    = sel1 ? y1       : y0;
    assign step_spd  = sel1 ? spd1     : spd0;
    assign step_pdir = sel1 ? pdir1    : pdir0;
    assign step_up   = sel1 ? up1_snap : up0_snap;
    assign step_dn   = sel1 ? dn1_snap : dn0_snap;

    paddle_step #(
        .PADDLE_HALF (PADDLE_HALF),
        .Y_MIN       (Y_MIN),
        .Y_MAX       (Y_MAX),
        .MAX_SPEED   (MAX_SPEED)
    ) u_step (
        .y          (step_y),
        .speed      (step_spd),
        .prev_dir   (step_pdir),
        .up         (step_up),
        .dn         (step_dn),
        .next_y     (next_y),
        .next_speed (next_spd),
        .next_dir   (next_dir)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            up0_snap <= 1'b0;
            dn0_snap <= 1'b0;
            up1_snap <= 1'b0;
            dn1_snap <= 1'b0;
            y0       <= POS_W'(Y_INIT);
            y1       <= POS_W'(Y_INIT);
            spd0     <= '0;
            spd1     <= '0;
            pdir0    <= 2'sd0;
            pdir1    <= 2'sd0;
        end else begin
            if (load_snap) begin
                up0_snap <= up0_key;
                dn0_snap <= dn0_key;
                up1_snap <= up1_key;
                dn1_snap <= dn1_key;
            end
            if (load0) begin
                y0    <= next_y;
                spd0  <= next_spd;
                pdir0 <= next_dir;
            end
            if (load1) begin
                y1    <= next_y;
                spd1  <= next_spd;
                pdir1 <= next_dir;
            end
        end
    end

    assign bus.Paddle0X    = POS_W'(P0_X);
    assign bus.Paddle1X    = POS_W'(P1_X);
    assign bus.paddle_size = POS_W'(PADDLE_HALF);
    assign bus.Paddle0Y    = y0;
    assign bus.Paddle1Y    = y1;
    assign bus.update_done = done;

endmodule

// File: tb/tb_paddle_controller.sv
// Directed bench for paddle_controller with a per-frame arithmetic model checked every cycle.
module tb_paddle_controller;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    paddle_controller_if bus();

    paddle_controller dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int errors  = 0;

    // Model: position, speed and last direction per paddle.
    int my[2];
    int ms[2];
    int mp[2];

    int   exp_y0   = 240;
    int   exp_y1   = 240;
    logic exp_done = 1'b0;

    int w_exp[4] = '{239, 237, 234, 230};
    int s_exp[8] = '{241, 243, 246, 250, 255, 261, 267, 273};

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            my[i] = 240;
            ms[i] = 0;
            mp[i] = 0;
        end
    endfunction

    function automatic void model_step(input int idx, input logic up, input logic dn);
        int dir;
        int cand;
        dir = (up && !dn) ? -1 : ((dn && !up) ? 1 : 0);
        if (dir == 0)
            ms[idx] = 0;
        else if (dir == mp[idx])
            ms[idx] = (ms[idx] + 1 > 6) ? 6 : ms[idx] + 1;
        else
            ms[idx] = 1;
        cand = my[idx] + dir * ms[idx];
        if (cand < 24) begin
            my[idx] = 24;
            ms[idx] = 0;
        end else if (cand > 455) begin
            my[idx] = 455;
            ms[idx] = 0;
        end else begin
            my[idx] = cand;
        end
        mp[idx] = dir;
    endfunction

    always @(negedge Clk) begin
        check("paddle0_y", int'(bus.Paddle0Y), exp_y0);
        check("paddle1_y", int'(bus.Paddle1Y), exp_y1);
        check("update_done", int'(bus.update_done), int'(exp_done));
        check("paddle0_x", int'(bus.Paddle0X), 40);
        check("paddle1_x", int'(bus.Paddle1X), 600);
        check("paddle_size", int'(bus.paddle_size), 24);
    end

    // Frame edge driven one step after a Clk edge, so the synchroniser delay is exact.
    task automatic do_frame(input logic [7:0] k0, input logic [7:0] k1,
                            input logic hl, input logic hold_mid);
        @(posedge Clk); #1;
        bus.keycode0  = k0;
        bus.keycode1  = k1;
        bus.hold      = hl;
        bus.frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        if (hold_mid) bus.hold = 1'b1;
        if (!hl) begin
            model_step(0, (k0 == 8'h1A) || (k1 == 8'h1A), (k0 == 8'h16) || (k1 == 8'h16));
            model_step(1, (k0 == 8'h52) || (k1 == 8'h52), (k0 == 8'h51) || (k1 == 8'h51));
        end
        @(posedge Clk); #1;
        if (!hl) exp_y0 = my[0];
        @(posedge Clk); #1;
        if (!hl) begin
            exp_y1   = my[1];
            exp_done = 1'b1;
        end
        @(posedge Clk); #1;
        exp_done      = 1'b0;
        bus.frame_clk = 1'b0;
        bus.hold      = 1'b0;
        bus.keycode0  = 8'h00;
        bus.keycode1  = 8'h00;
        repeat (3) @(posedge Clk);
    endtask

    initial begin
        bus.frame_clk = 1'b0;
        bus.hold      = 1'b0;
        bus.keycode0  = 8'h00;
        bus.keycode1  = 8'h00;
        model_reset();
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        check("reset_y0", int'(bus.Paddle0Y), 240);
        check("reset_y1", int'(bus.Paddle1Y), 240);
        check("reset_done", int'(bus.update_done), 0);
        repeat (2) @(posedge Clk);

        // W held: speed ramps 1,2,3,4.
        for (int i = 0; i < 4; i++) begin
            do_frame(8'h1A, 8'h00, 1'b0, 1'b0);
            check("w_ramp_y0", int'(bus.Paddle0Y), w_exp[i]);
            check("w_ramp_y1", int'(bus.Paddle1Y), 240);
        end

        // Async reset in the middle of a frame sequence.
        @(posedge Clk); #1;
        bus.keycode0  = 8'h16;
        bus.frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #3;
        Reset         = 1'b1;
        bus.frame_clk = 1'b0;
        bus.keycode0  = 8'h00;
        model_reset();
        exp_y0   = 240;
        exp_y1   = 240;
        exp_done = 1'b0;
        #1;
        check("midreset_y0", int'(bus.Paddle0Y), 240);
        check("midreset_y1", int'(bus.Paddle1Y), 240);
        check("midreset_done", int'(bus.update_done), 0);
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (3) @(posedge Clk);
        do_frame(8'h00, 8'h00, 1'b0, 1'b0);
        check("idle_after_reset_y0", int'(bus.Paddle0Y), 240);

        // S held 8 frames: capped at 6, then reversal restarts at 1.
        for (int i = 0; i < 8; i++) begin
            do_frame(8'h00, 8'h16, 1'b0, 1'b0);
            check("s_ramp_y0", int'(bus.Paddle0Y), s_exp[i]);
        end
        do_frame(8'h1A, 8'h00, 1'b0, 1'b0);
        check("reversal_y0", int'(bus.Paddle0Y), 272);

        // Up and Down together on paddle 1.
        do_frame(8'h52, 8'h51, 1'b0, 1'b0);
        check("both_keys_y1", int'(bus.Paddle1Y), 240);
        do_frame(8'h52, 8'h00, 1'b0, 1'b0);
        check("after_both_y1", int'(bus.Paddle1Y), 239);

        // Top clamp on paddle 0.
        for (int i = 0; i < 50; i++) do_frame(8'h1A, 8'h00, 1'b0, 1'b0);
        check("top_clamp_y0", int'(bus.Paddle0Y), 24);
        do_frame(8'h1A, 8'h00, 1'b0, 1'b0);
        check("top_stay_y0", int'(bus.Paddle0Y), 24);

        // Bottom clamp on paddle 1.
        for (int i = 0; i < 50; i++) do_frame(8'h00, 8'h51, 1'b0, 1'b0);
        check("bottom_clamp_y1", int'(bus.Paddle1Y), 455);
        do_frame(8'h51, 8'h00, 1'b0, 1'b0);
        check("bottom_stay_y1", int'(bus.Paddle1Y), 455);

        // Hold suppresses frames; motion resumes at speed 1.
        do_frame(8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_frame(8'h52, 8'h00, 1'b1, 1'b0);
            check("held_y1", int'(bus.Paddle1Y), 455);
        end
        do_frame(8'h52, 8'h00, 1'b0, 1'b0);
        check("resume_y1", int'(bus.Paddle1Y), 454);

        // Hold rising after the sequence has started does not abort it.
        do_frame(8'h52, 8'h00, 1'b0, 1'b1);
        check("hold_mid_y1", int'(bus.Paddle1Y), 452);

        @(posedge Clk);
        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
